// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - FSM state encodings (fetch_state_e)
//   - next-PC selector encodings (pc_sel_e)
//   - default address/instruction widths, reset PC and NOP encoding
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 16;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program-counter register with next-PC mux.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (loads RESET_PC)
//   sel          - next-PC select (pc_sel_e: hold / increment / redirect)
//   redirect_pc  - target loaded when sel == PC_REDIRECT
//   pc           - current PC (increment wraps modulo 2^ADDR_W)
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:      pc <= pc + 1'b1;
        PC_REDIRECT: pc <= redirect_pc;
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the ROM address and
// captures the combinational ROM word into an IF/ID register toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN;
// otherwise perf_fetched/perf_stalls are tied to zero.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   start                      - leave IDLE and begin fetching
//   imem_addr / imem_data      - ROM address (= PC) and same-cycle read data
//   out_valid/out_ready        - IF/ID handshake toward decode
//   out_instr/out_pc           - captured instruction and its PC
//   redirect_valid/redirect_pc - taken branch/jump: load PC, flush IF/ID
//   halt_req                   - stop fetching (exit via redirect or rst)
//   state_o                    - current FSM state (debug)
//   perf_fetched/perf_stalls   - capture and backpressure-cycle counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic [1:0]         state_o,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
);

  fetch_state_e      state_q, state_d;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_q;
  logic              load;
  logic              capture;
  logic              out_clear;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .sel         (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc_q)
  );

  assign imem_addr = pc_q;
  assign state_o   = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  // Redirect outranks both capture and halt for the PC; halt alone decides
  // the next state when both arrive together.
  always_comb begin
    state_d   = state_q;
    pc_sel    = PC_HOLD;
    capture   = 1'b0;
    out_clear = 1'b0;
    load      = !out_valid || out_ready;
    case (state_q)
      FETCH_IDLE: begin
        out_clear = 1'b1;
        if (start) state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          pc_sel    = PC_REDIRECT;
          out_clear = 1'b1;
        end else if (halt_req) begin
          // no capture; a pending word drains only once decode takes it
          out_clear = out_ready;
        end else if (load) begin
          pc_sel  = PC_INC;
          capture = 1'b1;
        end
        if (halt_req) state_d = FETCH_HALTED;
      end
      FETCH_HALTED: begin
        if (redirect_valid) begin
          pc_sel    = PC_REDIRECT;
          out_clear = 1'b1;
          if (!halt_req) state_d = FETCH_RUN;
        end else begin
          out_clear = out_ready;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        out_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= INSTR_W'(FETCH_NOP);
      out_pc    <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_instr <= imem_data;
      out_pc    <= pc_q;
    end else if (out_clear) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (capture) fetched_q <= fetched_q + 32'd1;
      if (state_q == FETCH_RUN && out_valid && !out_ready)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic [1:0]  state_o;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  // ROM model: mem[i] = i + 1
  assign imem_data = {16'h0000, imem_addr} + 32'd1;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .state_o        (state_o),
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] pc,
                         input logic [31:0] instr);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".pc"}, 64'(out_pc), 64'(pc));
    chk({tag, ".instr"}, 64'(out_instr), 64'(instr));
  endtask

  task automatic chk_perf(input string tag, input int unsigned f, input int unsigned s);
    chk({tag, ".perf_fetched"}, 64'(perf_fetched), PERF ? 64'(f) : 64'd0);
    chk({tag, ".perf_stalls"}, 64'(perf_stalls), PERF ? 64'(s) : 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst.state", 64'(state_o), 64'd0);
    chk_out("rst", 1'b0, 16'h0000, 32'h0);
    chk("rst.addr", 64'(imem_addr), 64'h0);
    chk_perf("rst", 0, 0);

    // start and first captures
    start = 1'b1; tick(); start = 1'b0;
    chk("start.state", 64'(state_o), 64'd1);
    chk("start.valid", 64'(out_valid), 64'd0);
    tick(); chk_out("cap0", 1'b1, 16'd0, 32'd1);
    tick(); chk_out("cap1", 1'b1, 16'd1, 32'd2);
    tick(); chk_out("cap2", 1'b1, 16'd2, 32'd3);
    tick(); tick(); tick();
    chk_out("cap5", 1'b1, 16'd5, 32'd6);

    // backpressure for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stall", 1'b1, 16'd5, 32'd6);
    end
    chk("stall.addr", 64'(imem_addr), 64'd6);
    chk_perf("stall", 6, 3);
    out_ready = 1'b1;
    tick(); chk_out("release", 1'b1, 16'd6, 32'd7);

    // redirect while stalled
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect_valid = 1'b0;
    chk("redir.valid", 64'(out_valid), 64'd0);
    chk("redir.addr", 64'(imem_addr), 64'h40);
    out_ready = 1'b1;
    tick(); chk_out("redir.tgt", 1'b1, 16'h0040, 32'h41);

    // halt with a pending word
    out_ready = 1'b0; halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    chk("halt.state", 64'(state_o), 64'd2);
    chk_out("halt.hold", 1'b1, 16'h0040, 32'h41);
    chk("halt.addr", 64'(imem_addr), 64'h41);
    out_ready = 1'b1;
    tick(); chk("halt.drain", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt.idle_valid", 64'(out_valid), 64'd0);
    end
    chk("halt.idle_addr", 64'(imem_addr), 64'h41);
    chk("halt.idle_state", 64'(state_o), 64'd2);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick(); redirect_valid = 1'b0;
    chk("resume.state", 64'(state_o), 64'd1);
    chk("resume.valid", 64'(out_valid), 64'd0);
    tick(); chk_out("resume.tgt", 1'b1, 16'h0010, 32'h11);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("wrap.ffff", 1'b1, 16'hFFFF, 32'h0001_0000);
    tick(); chk_out("wrap.0000", 1'b1, 16'h0000, 32'h1);
    chk("wrap.addr", 64'(imem_addr), 64'h1);
    chk_perf("wrap", 11, 5);

    // simultaneous halt + redirect: halt takes state, redirect takes PC
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0020;
    tick(); halt_req = 1'b0; redirect_valid = 1'b0;
    chk("both.state", 64'(state_o), 64'd2);
    chk("both.valid", 64'(out_valid), 64'd0);
    chk("both.addr", 64'(imem_addr), 64'h20);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("both.start_ignored", 64'(state_o), 64'd2);
    chk("both.nocap", 64'(out_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0030;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("both.resume", 1'b1, 16'h0030, 32'h31);

    // reset in the middle of a stall
    out_ready = 1'b0;
    tick();
    chk_perf("prerst", 12, 6);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("midrst.state", 64'(state_o), 64'd0);
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.addr", 64'(imem_addr), 64'h0);
    chk_perf("midrst", 0, 0);

    // redirect in IDLE is ignored
    redirect_valid = 1'b1; redirect_pc = 16'h0050;
    tick(); redirect_valid = 1'b0;
    chk("idle.redir_state", 64'(state_o), 64'd0);
    chk("idle.redir_addr", 64'(imem_addr), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
